// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through L1 miss/store channel: in-order request queue,
// programmable per-request latency and a banked word array. Optional counters: WT_MEM_RESP_STATS_EN.
module wt_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_WIDTH = 128,
    parameter int TID_WIDTH  = 2,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_type_i,
    input  logic                    req_nc_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [TID_WIDTH-1:0]    req_tid_i,
    output logic                    rtrn_valid_o,
    input  logic                    rtrn_ready_i,
    output logic [1:0]              rtrn_type_o,
    output logic [TID_WIDTH-1:0]    rtrn_tid_o,
    output logic [LINE_WIDTH-1:0]   rtrn_data_o
`ifdef WT_MEM_RESP_STATS_EN
    ,
    output logic [31:0]             stat_loads_o,
    output logic [31:0]             stat_stores_o,
    output logic [31:0]             stat_ifills_o
`endif
);
    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int LINE_WORDS = LINE_WIDTH / DATA_WIDTH;
    localparam int WOFF       = $clog2(BE_W);
    localparam int LINE_LN    = $clog2(LINE_WORDS);
    localparam int LANE_W     = (LINE_WORDS > 1) ? LINE_LN : 1;
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int BANK_DEPTH = MEM_WORDS / LINE_WORDS;
    localparam int BANK_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [1:0] T_LOAD  = 2'b00;
    localparam logic [1:0] T_STORE = 2'b01;
    localparam logic [1:0] T_IFILL = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {K_ZERO, K_LINE, K_NC} kind_t;

    typedef struct packed {
        logic [1:0]            typ;
        logic                  nc;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TID_WIDTH-1:0]  tid;
    } req_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> WOFF);
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input logic [IDX_W-1:0] idx);
        if (LINE_WORDS > 1) return LANE_W'(idx);
        return '0;
    endfunction

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill, fill_d;
    logic                 ready_q, ready_d;
    logic                 rtrn_valid_q, rtrn_valid_d;
    logic [1:0]           rtrn_type_q, rtrn_type_d;
    logic [TID_WIDTH-1:0] rtrn_tid_q, rtrn_tid_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    req_t                 work_q, work_d, op, head, req_in;
    req_t                 fifo_mem [FIFO_DEPTH];
    logic                 push, pop, empty, go_resp, mem_wr_en, mem_rd_en;
    logic [IDX_W-1:0]     op_idx;
    logic [LANE_W-1:0]    op_lane;
    logic [BANK_W-1:0]    op_row;
    logic [LINE_WIDTH-1:0] line_rd;
    logic [DATA_WIDTH-1:0] nc_word;

    assign req_in   = '{typ: req_type_i, nc: req_nc_i, addr: req_addr_i, be: req_be_i,
                        wdata: req_wdata_i, tid: req_tid_i};
    assign push     = req_valid_i && ready_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign head     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    assign fill_d   = fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    // Ready looks at next-cycle occupancy only, so a full queue never accepts even on a pop.
    assign ready_d  = (fill_d != (PTR_W+1)'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= req_in;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        op           = work_q;
        pop          = 1'b0;
        go_resp      = 1'b0;
        rtrn_valid_d = rtrn_valid_q;
        rtrn_type_d  = rtrn_type_q;
        rtrn_tid_d   = rtrn_tid_q;
        kind_d       = kind_q;
        lane_d       = lane_q;
        case (state_q)
            IDLE: if (!empty) begin
                pop    = 1'b1;
                work_d = head;
                op     = head;
                if (LATENCY == 0) begin
                    go_resp = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: if (cnt_q == 4'd0) go_resp = 1'b1;
                  else cnt_d = cnt_q - 4'd1;
            RESP: if (rtrn_ready_i) begin
                state_d      = IDLE;
                rtrn_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            state_d      = RESP;
            rtrn_valid_d = 1'b1;
            rtrn_type_d  = op.typ;
            rtrn_tid_d   = op.tid;
            lane_d       = lane_of(word_idx(op.addr));
            case (op.typ)
                T_LOAD:  kind_d = op.nc ? K_NC : K_LINE;
                T_IFILL: kind_d = K_LINE;
                default: kind_d = K_ZERO;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            kind_q       <= K_ZERO;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ready_q      <= 1'b1;
            work_q       <= '0;
            rtrn_valid_q <= 1'b0;
            rtrn_type_q  <= '0;
            rtrn_tid_q   <= '0;
            lane_q       <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ready_q      <= ready_d;
            work_q       <= work_d;
            rtrn_valid_q <= rtrn_valid_d;
            rtrn_type_q  <= rtrn_type_d;
            rtrn_tid_q   <= rtrn_tid_d;
            lane_q       <= lane_d;
        end
    end

    // Words are striped across one bank per line lane, so a whole aligned line is one row.
    assign op_idx    = word_idx(op.addr);
    assign op_lane   = lane_of(op_idx);
    assign op_row    = BANK_W'(op_idx >> LINE_LN);
    assign mem_wr_en = go_resp && (op.typ == T_STORE);
    assign mem_rd_en = go_resp && ((op.typ == T_LOAD) || (op.typ == T_IFILL));

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] bank_mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] bank_rd_q;
        always_ff @(posedge clk_i) begin
            if (mem_wr_en && (op_lane == LANE_W'(gi))) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (op.be[b]) bank_mem[op_row][b*8 +: 8] <= op.wdata[b*8 +: 8];
                end
            end
            if (mem_rd_en) bank_rd_q <= bank_mem[op_row];
        end
        assign line_rd[gi*DATA_WIDTH +: DATA_WIDTH] = bank_rd_q;
    end

    assign nc_word = line_rd[lane_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        rtrn_data_o = '0;
        case (kind_q)
            K_LINE:  rtrn_data_o = line_rd;
            K_NC:    rtrn_data_o = {LINE_WORDS{nc_word}};
            default: rtrn_data_o = '0;
        endcase
    end

    assign req_ready_o  = ready_q;
    assign rtrn_valid_o = rtrn_valid_q;
    assign rtrn_type_o  = rtrn_type_q;
    assign rtrn_tid_o   = rtrn_tid_q;

`ifdef WT_MEM_RESP_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d, stat_stores_q, stat_stores_d, stat_ifills_q, stat_ifills_d;

    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_ifills_d = stat_ifills_q;
        if (rtrn_valid_q && rtrn_ready_i) begin
            case (rtrn_type_q)
                T_LOAD:  if (stat_loads_q  != '1) stat_loads_d  = stat_loads_q  + 32'd1;
                T_STORE: if (stat_stores_q != '1) stat_stores_d = stat_stores_q + 32'd1;
                T_IFILL: if (stat_ifills_q != '1) stat_ifills_d = stat_ifills_q + 32'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_ifills_q <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_ifills_q <= stat_ifills_d;
        end
    end

    assign stat_loads_o  = stat_loads_q;
    assign stat_stores_o = stat_stores_q;
    assign stat_ifills_o = stat_ifills_q;
`endif
endmodule

// File: tb/tb_wt_mem_responder.sv
// Self-checking bench for wt_mem_responder: directed steps plus a randomized phase, all
// responses compared against a word-array reference model and an in-order expectation queue.
module tb_wt_mem_responder;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int LW  = 128;
    localparam int TW  = 2;
    localparam int MW  = 1024;
    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int NL  = LW / DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_type = '0;
    logic          req_nc = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW/8-1:0] req_be = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [TW-1:0] req_tid = '0;
    logic          rtrn_valid_o;
    logic          rtrn_ready = 1'b0;
    logic [1:0]    rtrn_type_o;
    logic [TW-1:0] rtrn_tid_o;
    logic [LW-1:0] rtrn_data_o;
`ifdef WT_MEM_RESP_STATS_EN
    logic [31:0]   stat_loads_o, stat_stores_o, stat_ifills_o;
`endif

    wt_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .TID_WIDTH(TW),
        .MEM_WORDS(MW), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_type_i(req_type),
        .req_nc_i(req_nc), .req_addr_i(req_addr), .req_be_i(req_be),
        .req_wdata_i(req_wdata), .req_tid_i(req_tid),
        .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready), .rtrn_type_o(rtrn_type_o),
        .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o)
`ifdef WT_MEM_RESP_STATS_EN
        , .stat_loads_o(stat_loads_o), .stat_stores_o(stat_stores_o), .stat_ifills_o(stat_ifills_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    typ;
        logic [TW-1:0] tid;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mmem [MW];
    int            checks = 0;
    int            errors = 0;
    int            n_loads = 0, n_stores = 0, n_ifills = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a flat word array; lines are N consecutive words from the aligned line address.
    task automatic model_req(input logic [1:0] typ, input logic nc, input logic [AW-1:0] addr,
                             input logic [DW/8-1:0] be, input logic [DW-1:0] wd,
                             input logic [TW-1:0] tid, output exp_t e);
        int idx;
        logic [AW-1:0] line_addr;
        e.typ  = typ;
        e.tid  = tid;
        e.data = '0;
        idx = int'((addr / (DW/8)) % MW);
        line_addr = addr - (addr % (LW/8));
        if (typ == 2'b00 && nc) begin
            for (int n = 0; n < NL; n++) e.data[n*DW +: DW] = mmem[idx];
        end else if (typ == 2'b00 || typ == 2'b10) begin
            for (int n = 0; n < NL; n++)
                e.data[n*DW +: DW] = mmem[int'((line_addr / (DW/8) + n) % MW)];
        end else if (typ == 2'b01) begin
            for (int b = 0; b < DW/8; b++)
                if (be[b]) mmem[idx][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    task automatic push_req(input logic [1:0] typ, input logic nc, input logic [AW-1:0] addr,
                            input logic [DW/8-1:0] be, input logic [DW-1:0] wd,
                            input logic [TW-1:0] tid, input bit use_model, output int waits);
        bit   acc;
        logic rdy;
        exp_t e;
        req_valid = 1'b1; req_type = typ; req_nc = nc; req_addr = addr;
        req_be = be; req_wdata = wd; req_tid = tid;
        acc = 0;
        waits = 0;
        for (int k = 0; k < 100 && !acc; k++) begin
            rdy = req_ready_o;
            @(posedge clk); #1;
            if (rdy === 1'b1) acc = 1;
            else waits++;
        end
        req_valid = 1'b0;
        chk("push_accepted", LW'(acc), LW'(1));
        if (acc && use_model) begin
            model_req(typ, nc, addr, be, wd, tid, e);
            sb.push_back(e);
        end
        $display("push   typ=%0d nc=%0d addr=%h be=%h wdata=%h tid=%0d waits=%0d",
                 typ, nc, addr, be, wd, tid, waits);
    endtask

    task automatic collect(output int first_cyc, output int hs_cyc, output logic [LW-1:0] data);
        bit   seen;
        exp_t e;
        seen = 0;
        first_cyc = -1;
        hs_cyc = -1;
        data = '0;
        rtrn_ready = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (rtrn_valid_o === 1'b1) begin
                seen = 1;
                first_cyc = cyc;
                data = rtrn_data_o;
                chk("resp_expected", LW'(sb.size() != 0), LW'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rtrn_type", LW'(rtrn_type_o), LW'(e.typ));
                    chk("rtrn_tid", LW'(rtrn_tid_o), LW'(e.tid));
                    chk("rtrn_data", rtrn_data_o, e.data);
                    case (e.typ)
                        2'b00: n_loads++;
                        2'b01: n_stores++;
                        2'b10: n_ifills++;
                        default: ;
                    endcase
                end
                $display("resp   typ=%0d tid=%0d data=%h cyc=%0d", rtrn_type_o, rtrn_tid_o,
                         rtrn_data_o, cyc);
                @(posedge clk); #1;
                hs_cyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("resp_timeout", LW'(seen), LW'(1));
        rtrn_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, LW'(req_ready_o), LW'(1));
        chk({tag, "_valid"}, LW'(rtrn_valid_o), LW'(0));
        chk({tag, "_type"}, LW'(rtrn_type_o), LW'(0));
        chk({tag, "_tid"}, LW'(rtrn_tid_o), LW'(0));
        chk({tag, "_data"}, rtrn_data_o, LW'(0));
    endtask

    initial begin
        int            w, fv, hs, acc_cyc;
        int            hs_arr[4];
        logic [LW-1:0] d;
        logic [LW-1:0] held_data;
        bit            seen;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- initialise the words the rest of the bench reads ----
        for (int i = 0; i < 16; i++) begin
            push_req(2'b01, 1'b0, AW'(i * 8), 8'hFF, 64'h0, TW'(i), 1, w);
            collect(fv, hs, d);
        end

        // ---- store then ifill, with latency check ----
        push_req(2'b01, 1'b0, 32'h10, 8'hFF, 64'h1122334455667788, 2'd1, 1, w);
        acc_cyc = cyc;
        collect(fv, hs, d);
        // Accepted in cycle T, valid in cycle T+2+LAT: LAT+1 edges after the accepting edge.
        chk("store_latency", LW'(fv - acc_cyc), LW'(LAT + 1));
        chk("store_data_zero", d, LW'(0));
        push_req(2'b10, 1'b0, 32'h18, 8'h00, 64'h0, 2'd2, 1, w);
        collect(fv, hs, d);
        chk("ifill_low_word", LW'(d[63:0]), LW'(64'h1122334455667788));

        // ---- partial store then non-cacheable load ----
        push_req(2'b01, 1'b0, 32'h20, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 2'd3, 1, w);
        collect(fv, hs, d);
        push_req(2'b00, 1'b1, 32'h20, 8'h00, 64'h0, 2'd0, 1, w);
        collect(fv, hs, d);
        chk("nc_load_lanes", d, {64'h0000_0000_BBBB_BBBB, 64'h0000_0000_BBBB_BBBB});

        // ---- fill the queue while responses are stalled ----
        for (int i = 0; i < 5; i++) begin
            push_req(2'b00, 1'b0, AW'(i * 16), 8'h00, 64'h0, TW'(i % 4), 1, w);
            chk("fill_no_wait", LW'(w), LW'(0));
        end
        chk("full_not_ready", LW'(req_ready_o), LW'(0));
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (rtrn_valid_o === 1'b1) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("stall_valid_seen", LW'(seen), LW'(1));
        held_data = rtrn_data_o;
        repeat (3) begin @(posedge clk); #1; end
        chk("stall_valid_held", LW'(rtrn_valid_o), LW'(1));
        chk("stall_tid_held", LW'(rtrn_tid_o), LW'(sb[0].tid));
        chk("stall_data_held", rtrn_data_o, held_data);
        chk("stall_still_full", LW'(req_ready_o), LW'(0));
        for (int i = 0; i < 5; i++) collect(fv, hs, d);

        // ---- sustained throughput with response ready held high ----
        fork
            begin
                int pw;
                for (int i = 0; i < 4; i++)
                    push_req((i == 3) ? 2'b10 : 2'b00, 1'b0, AW'(i * 16 + 8), 8'h00, 64'h0,
                             (i == 3) ? 2'd3 : TW'(i), 1, pw);
            end
            begin
                int cf;
                logic [LW-1:0] cd;
                for (int i = 0; i < 4; i++) collect(cf, hs_arr[i], cd);
            end
        join
        for (int i = 1; i < 4; i++)
            chk("throughput_spacing", LW'(hs_arr[i] - hs_arr[i-1]), LW'(LAT + 2));

        // ---- reset while a request waits and two more are queued ----
        push_req(2'b01, 1'b0, 32'h28, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 2'd1, 0, w);
        push_req(2'b00, 1'b0, 32'h28, 8'h00, 64'h0, 2'd2, 0, w);
        push_req(2'b10, 1'b0, 32'h30, 8'h00, 64'h0, 2'd3, 0, w);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
`ifdef WT_MEM_RESP_STATS_EN
        chk("midreset_stat_loads", LW'(stat_loads_o), LW'(0));
`endif
        n_loads = 0; n_stores = 0; n_ifills = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rtrn_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rtrn_valid_o !== 1'b0) seen = 1;
        end
        rtrn_ready = 1'b0;
        chk("discarded_no_resp", LW'(seen), LW'(0));
        push_req(2'b00, 1'b1, 32'h28, 8'h00, 64'h0, 2'd1, 1, w);
        acc_cyc = cyc;
        collect(fv, hs, d);
        chk("post_reset_latency", LW'(fv - acc_cyc), LW'(LAT + 1));

        // ---- randomized traffic with random response stalls ----
        fork
            begin
                int pw;
                logic [1:0] t;
                logic [AW-1:0] a;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    t = 2'($urandom_range(0, 3));
                    a = ($urandom & 32'hFFFF_E000) | (AW'($urandom_range(0, 15)) << 3)
                        | ($urandom & 32'h7);
                    push_req(t, 1'($urandom), a, 8'($urandom), {$urandom, $urandom},
                             TW'($urandom), 1, pw);
                end
            end
            begin
                int cf, ch;
                logic [LW-1:0] cd;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    collect(cf, ch, cd);
                end
            end
        join

`ifdef WT_MEM_RESP_STATS_EN
        chk("stat_loads", LW'(stat_loads_o), LW'(n_loads));
        chk("stat_stores", LW'(stat_stores_o), LW'(n_stores));
        chk("stat_ifills", LW'(stat_ifills_o), LW'(n_ifills));
`endif
        chk("scoreboard_drained", LW'(sb.size()), LW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
